// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between bus masters and the round-robin arbiter.
// The arbiter takes the slave modport; masters and slaves drive the other side.
interface bus_arbiter_rr_if #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 3
);
  logic [NUM_CH-1:0] DMA;
  logic              BUS_ready;
  logic [NUM_CH-1:0] grant;
  logic              BUS_req;
  logic [CH_W-1:0]   owner;
  logic              busy;
  logic              timeout_err;
  logic [CH_W-1:0]   err_ch;

  modport slave (
    input  DMA, BUS_ready,
    output grant, BUS_req, owner, busy, timeout_err, err_ch
  );

  modport master (
    output DMA, BUS_ready,
    input  grant, BUS_req, owner, busy, timeout_err, err_ch
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// NUM_CH-way bus arbiter, round-robin or fixed priority, grant held until release.
// Optional watchdog release is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter_rr #(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = 3,
  parameter int PRIO_MODE   = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input logic            clk,
  input logic            clr,
  bus_arbiter_rr_if.slave bus
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state, state_n;
  logic [NUM_CH-1:0] grant_q, grant_n;
  logic [CH_W-1:0]   owner_q, owner_n;
  logic [CH_W-1:0]   ptr_q, ptr_n, nxt_ptr;
  logic [NUM_CH-1:0] mask_q, cand;
  logic [CH_W-1:0]   start;
  logic [CH_W:0]     sel;
  logic              own_req, hit, release_c;

  // {valid, index} of the first set bit searching upward from s, wrapping
  function automatic logic [CH_W:0] pick(
    input logic [NUM_CH-1:0] r,
    input logic [CH_W-1:0]   s
  );
    logic [CH_W:0] res;
    int            idx;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(s) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (r[idx]) res = {1'b1, CH_W'(idx)};
    end
    return res;
  endfunction

  assign own_req   = bus.DMA[owner_q];
  assign release_c = (state == OWN) && (!own_req || hit);
  assign nxt_ptr   = (owner_q == CH_W'(NUM_CH - 1)) ?
                     '0 : owner_q + CH_W'(1);

  always_comb begin
    cand  = bus.DMA & ~mask_q;
    start = ptr_q;
    if (state == OWN) begin
      cand  = cand & ~grant_q;
      start = nxt_ptr;
    end
    if (PRIO_MODE != 0) start = '0;
    sel = pick(cand, start);
  end

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    owner_n = owner_q;
    ptr_n   = ptr_q;
    unique case (state)
      IDLE: begin
        if (sel[CH_W]) begin
          grant_n                = '0;
          grant_n[sel[CH_W-1:0]] = 1'b1;
          owner_n                = sel[CH_W-1:0];
          state_n                = OWN;
        end
      end
      OWN: begin
        if (release_c) begin
          ptr_n   = nxt_ptr;
          grant_n = '0;
          if (sel[CH_W]) begin
            grant_n[sel[CH_W-1:0]] = 1'b1;
            owner_n                = sel[CH_W-1:0];
          end else begin
            owner_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      owner_q <= owner_n;
      ptr_q   <= ptr_n;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0]       cnt_q;
  logic              terr_q;
  logic [CH_W-1:0]   ech_q;
  logic [NUM_CH-1:0] mask_n;
  logic              entry;

  assign hit   = (state == OWN) && own_req && !bus.BUS_ready &&
                 (cnt_q == 16'(TIMEOUT_CYC - 1));
  assign entry = (state_n == OWN) && ((state == IDLE) || release_c);

  // a timed-out channel stays masked until it lowers its request once
  always_comb begin
    mask_n = mask_q & bus.DMA;
    if (hit) mask_n[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
      ech_q  <= '0;
      mask_q <= '0;
    end else begin
      mask_q <= mask_n;
      if (entry) cnt_q <= '0;
      else if (state == OWN)
        cnt_q <= bus.BUS_ready ? 16'd0 : cnt_q + 16'd1;
      if (hit) begin
        terr_q <= 1'b1;
        ech_q  <= owner_q;
      end
    end
  end

  assign bus.timeout_err = terr_q;
  assign bus.err_ch      = ech_q;
`else
  assign hit             = 1'b0;
  assign mask_q          = '0;
  assign bus.timeout_err = 1'b0;
  assign bus.err_ch      = '0;
`endif

  assign bus.grant   = grant_q;
  assign bus.BUS_req = |grant_q;
  assign bus.busy    = |grant_q;
  assign bus.owner   = owner_q;

endmodule
